// File: rtl/piso_serializer.sv
// Parallel-in/serial-out frame serializer, MSB first.
// Feeds the serial input of the downstream shift-register stage.
module piso_serializer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             x,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             x_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      x     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      x     <= x_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    x_n     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          sreg_n  = din;
          cnt_n   = CW'(WIDTH - 1);
          state_n = SHIFT;
          x_n     = din[WIDTH-1];
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sreg_n = sreg << 1;
          cnt_n  = cnt - 1'b1;
          x_n    = sreg[WIDTH-2];
        end else begin
          // Mandatory IDLE cycle carries the done pulse
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Flag outputs decode straight from the state register
  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer, including a model of
// the downstream 6-bit shift register on the same clock.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clear;
  logic [5:0] din;
  logic       load;
  logic       ready;
  logic       busy;
  logic       x;
  logic       done;
  logic [5:0] dq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(6)) dut (
    .clk   (clk),
    .clear (clear),
    .din   (din),
    .load  (load),
    .ready (ready),
    .busy  (busy),
    .x     (x),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (clear) dq <= '0;
    else       dq <= {dq[4:0], x};
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag, input logic d);
    chk({tag, ".x"}, 8'(x), 8'd0);
    chk({tag, ".ready"}, 8'(ready), 8'd1);
    chk({tag, ".busy"}, 8'(busy), 8'd0);
    chk({tag, ".done"}, 8'(done), 8'(d));
  endtask

  // Check six frame bits; optional load pulse at bit index pk
  task automatic frame(input string tag, input logic [5:0] w,
                       input int pk, input logic [5:0] pd);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s.x%0d", tag, k), 8'(x), 8'(w[5-k]));
      chk($sformatf("%s.busy%0d", tag, k), 8'(busy), 8'd1);
      chk($sformatf("%s.rdy%0d", tag, k), 8'(ready), 8'd0);
      chk($sformatf("%s.done%0d", tag, k), 8'(done), 8'd0);
      if (pk >= 0) begin
        load = (k == pk);
        if (k == pk) din = pd;
      end
      tick();
    end
  endtask

  initial begin
    clear = 1'b1;
    load  = 1'b1;
    din   = 6'b111111;
    tick();
    idle_chk("rst1", 1'b0);
    tick();
    idle_chk("rst2", 1'b0);
    clear = 1'b0;
    load  = 1'b0;
    tick();
    idle_chk("rst3", 1'b0);

    // single frame
    din  = 6'b101100;
    load = 1'b1;
    tick();
    load = 1'b0;
    frame("single", 6'b101100, -1, '0);
    idle_chk("single.end", 1'b1);
    tick();
    idle_chk("single.post", 1'b0);

    // back-to-back, load held high throughout
    din  = 6'b100001;
    load = 1'b1;
    tick();
    din  = 6'b011110;
    frame("b2b1", 6'b100001, -1, '0);
    idle_chk("b2b.gap", 1'b1);
    tick();
    load = 1'b0;
    frame("b2b2", 6'b011110, -1, '0);
    idle_chk("b2b.end", 1'b1);
    tick();
    idle_chk("b2b.post", 1'b0);

    // load pulse while busy is ignored
    din  = 6'b110000;
    load = 1'b1;
    tick();
    load = 1'b0;
    frame("busyld", 6'b110000, 2, 6'b001111);
    load = 1'b0;
    idle_chk("busyld.end", 1'b1);
    tick();
    idle_chk("busyld.post", 1'b0);

    // abort with clear at the 4th bit
    din  = 6'b111111;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort.x%0d", k), 8'(x), 8'd1);
      if (k == 3) clear = 1'b1;
      tick();
    end
    clear = 1'b0;
    idle_chk("abort.after", 1'b0);
    tick();
    idle_chk("abort.after2", 1'b0);
    din  = 6'b000001;
    load = 1'b1;
    tick();
    load = 1'b0;
    frame("fresh", 6'b000001, -1, '0);
    idle_chk("fresh.end", 1'b1);
    tick();

    // downstream shift register integration
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ds.zero", 8'(dq), 8'd0);
    din  = 6'b100000;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("ds.q%0d", k), 8'(dq), 8'(1 << k));
    end
    chk("ds.done", 8'(done), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
